// File: rtl/router_src_rx.sv
// Source-side receiver of the 1x3 router: decodes byte-serial packets, steers every
// accepted byte into the addressed destination FIFO, back-pressures on full and flags bad packets.
module router_src_rx #(
  parameter int NUM_DEST = 3,
  parameter int ADDR_W   = 2,
  parameter int DATA_W   = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                pkt_valid,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [NUM_DEST-1:0] fifo_full,
  output logic                busy,
  output logic                err,
  output logic [NUM_DEST-1:0] fifo_wr_en,
  output logic [DATA_W-1:0]   fifo_din,
  output logic                pkt_done
);

  localparam int LEN_W = DATA_W - ADDR_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_DATA = 2'd1,
    DROP      = 2'd2,
    CHECK     = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                len_err_q, len_err_d;
  logic                par_err_q, par_err_d;
  logic                addr_err_q, addr_err_d;
  logic                err_q, err_d;
  logic [NUM_DEST-1:0] wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                done_q, done_d;

  logic [ADDR_W-1:0]   addr;
  logic                addr_valid;
  logic [NUM_DEST-1:0] addr_onehot;
  logic [NUM_DEST-1:0] dest_onehot;
  logic                full_at_addr;
  logic                dest_full;

  assign addr       = data_in[ADDR_W-1:0];
  // One extra bit so the compare also works when NUM_DEST == 2**ADDR_W.
  assign addr_valid = ({1'b0, addr} < (ADDR_W+1)'(NUM_DEST));

  // Decode both the incoming header address and the latched destination to one-hot,
  // so FIFO full flags are selected without out-of-range indexing.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DEST; gi++) begin : g_decode
      assign addr_onehot[gi] = (addr == ADDR_W'(gi));
      assign dest_onehot[gi] = (dest_q == ADDR_W'(gi));
    end
  endgenerate

  assign full_at_addr = |(fifo_full & addr_onehot);
  assign dest_full    = |(fifo_full & dest_onehot);

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    len_err_d  = len_err_q;
    par_err_d  = par_err_q;
    addr_err_d = addr_err_q;
    err_d      = err_q;
    wr_en_d    = '0;
    din_d      = din_q;
    done_d     = 1'b0;
    busy       = 1'b0;

    case (state_q)
      IDLE: begin
        busy = pkt_valid & addr_valid & full_at_addr;
        if (pkt_valid && !busy) begin
          dest_d     = addr;
          len_d      = data_in[DATA_W-1:ADDR_W];
          acc_d      = data_in;
          cnt_d      = '0;
          len_err_d  = 1'b0;
          par_err_d  = 1'b0;
          addr_err_d = 1'b0;
          if (addr_valid) begin
            wr_en_d = addr_onehot;
            din_d   = data_in;
            err_d   = 1'b0;
            state_d = LOAD_DATA;
          end else begin
            state_d = DROP;
          end
        end
      end

      LOAD_DATA: begin
        busy = dest_full;
        if (!dest_full) begin
          wr_en_d = dest_onehot;
          din_d   = data_in;
          if (pkt_valid) begin
            acc_d = acc_q ^ data_in;
            // Saturate rather than wrap so an overlong packet stays flagged.
            if (cnt_q == len_q) begin
              len_err_d = 1'b1;
            end else begin
              cnt_d = cnt_q + LEN_W'(1);
            end
          end else begin
            par_err_d = (acc_q != data_in);
            if (cnt_q != len_q) begin
              len_err_d = 1'b1;
            end
            state_d = CHECK;
          end
        end
      end

      DROP: begin
        if (!pkt_valid) begin
          addr_err_d = 1'b1;
          state_d    = CHECK;
        end
      end

      CHECK: begin
        busy    = 1'b1;
        err_d   = par_err_q | len_err_q | addr_err_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      dest_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      len_err_q  <= 1'b0;
      par_err_q  <= 1'b0;
      addr_err_q <= 1'b0;
      err_q      <= 1'b0;
      wr_en_q    <= '0;
      din_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      len_err_q  <= len_err_d;
      par_err_q  <= par_err_d;
      addr_err_q <= addr_err_d;
      err_q      <= err_d;
      wr_en_q    <= wr_en_d;
      din_q      <= din_d;
      done_q     <= done_d;
    end
  end

  assign err        = err_q;
  assign fifo_wr_en = wr_en_q;
  assign fifo_din   = din_q;
  assign pkt_done   = done_q;

endmodule

// File: tb/tb_router_src_rx.sv
// Directed, table-driven bench for router_src_rx: each vector drives one cycle of
// inputs and checks busy before the edge and the registered outputs just after it.
module tb_router_src_rx;

  logic       clk;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic       busy;
  logic       err;
  logic [2:0] fifo_wr_en;
  logic [7:0] fifo_din;
  logic       pkt_done;

  int total = 0;
  int bad   = 0;

  router_src_rx #(.NUM_DEST(3), .ADDR_W(2), .DATA_W(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pkt_valid  (pkt_valid),
    .data_in    (data_in),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .err        (err),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .pkt_done   (pkt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       pv;
    logic [7:0] d;
    logic [2:0] full;
    logic       busy;
    logic [2:0] wr;
    logic [7:0] din;
    logic       done;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic pv, input logic [7:0] d, input logic [2:0] full,
                              input logic b, input logic [2:0] wr, input logic [7:0] din,
                              input logic done, input logic e);
    vec_t v;
    v.pv = pv; v.d = d; v.full = full; v.busy = b;
    v.wr = wr; v.din = din; v.done = done; v.err = e;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of stimulus; busy is checked before the edge, registered outputs after it.
  task automatic apply(input vec_t v, input int idx);
    pkt_valid = v.pv;
    data_in   = v.d;
    fifo_full = v.full;
    #1;
    chk("busy", idx, 32'(busy), 32'(v.busy));
    @(posedge clk);
    #1;
    chk("wr_en", idx, 32'(fifo_wr_en), 32'(v.wr));
    if (v.wr != 3'b000) chk("din", idx, 32'(fifo_din), 32'(v.din));
    chk("done", idx, 32'(pkt_done), 32'(v.done));
    chk("err", idx, 32'(err), 32'(v.err));
    $display("vec %0d pv=%0b d=%02h full=%03b -> busy=%0b wr=%03b din=%02h done=%0b err=%0b",
             idx, v.pv, v.d, v.full, v.busy, fifo_wr_en, fifo_din, pkt_done, err);
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) apply(vecs[i], i);
  endtask

  initial begin
    // Good packet 0x11 with an initial idle cycle and a header stall (indices 0..8).
    vecs.push_back(mk(0, 8'h00, 3'b000, 0, 3'b000, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'h11, 3'b010, 1, 3'b000, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'h11, 3'b000, 0, 3'b010, 8'h11, 0, 0));
    vecs.push_back(mk(1, 8'h01, 3'b000, 0, 3'b010, 8'h01, 0, 0));
    vecs.push_back(mk(1, 8'h02, 3'b000, 0, 3'b010, 8'h02, 0, 0));
    vecs.push_back(mk(1, 8'h03, 3'b000, 0, 3'b010, 8'h03, 0, 0));
    vecs.push_back(mk(1, 8'h04, 3'b000, 0, 3'b010, 8'h04, 0, 0));
    vecs.push_back(mk(0, 8'h15, 3'b000, 0, 3'b010, 8'h15, 0, 0));
    vecs.push_back(mk(0, 8'h00, 3'b000, 1, 3'b000, 8'h00, 1, 0));
    // Parity error, err holds through idle, then header 0x0C clears it (9..22).
    vecs.push_back(mk(1, 8'h11, 3'b000, 0, 3'b010, 8'h11, 0, 0));
    vecs.push_back(mk(1, 8'h01, 3'b000, 0, 3'b010, 8'h01, 0, 0));
    vecs.push_back(mk(1, 8'h02, 3'b000, 0, 3'b010, 8'h02, 0, 0));
    vecs.push_back(mk(1, 8'h03, 3'b000, 0, 3'b010, 8'h03, 0, 0));
    vecs.push_back(mk(1, 8'h04, 3'b000, 0, 3'b010, 8'h04, 0, 0));
    vecs.push_back(mk(0, 8'h16, 3'b000, 0, 3'b010, 8'h16, 0, 0));
    vecs.push_back(mk(0, 8'h00, 3'b000, 1, 3'b000, 8'h00, 1, 1));
    vecs.push_back(mk(0, 8'h00, 3'b000, 0, 3'b000, 8'h00, 0, 1));
    vecs.push_back(mk(1, 8'h0C, 3'b000, 0, 3'b001, 8'h0C, 0, 0));
    vecs.push_back(mk(1, 8'h10, 3'b000, 0, 3'b001, 8'h10, 0, 0));
    vecs.push_back(mk(1, 8'h20, 3'b000, 0, 3'b001, 8'h20, 0, 0));
    vecs.push_back(mk(1, 8'h30, 3'b000, 0, 3'b001, 8'h30, 0, 0));
    vecs.push_back(mk(0, 8'h0C, 3'b000, 0, 3'b001, 8'h0C, 0, 0));
    vecs.push_back(mk(0, 8'h00, 3'b000, 1, 3'b000, 8'h00, 1, 0));
    // Back-pressure on FIFO 2, back-to-back after CHECK (23..30).
    vecs.push_back(mk(1, 8'h0A, 3'b000, 0, 3'b100, 8'h0A, 0, 0));
    vecs.push_back(mk(1, 8'h55, 3'b011, 0, 3'b100, 8'h55, 0, 0));
    vecs.push_back(mk(1, 8'h66, 3'b100, 1, 3'b000, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'h66, 3'b100, 1, 3'b000, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'h66, 3'b100, 1, 3'b000, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'h66, 3'b000, 0, 3'b100, 8'h66, 0, 0));
    vecs.push_back(mk(0, 8'h39, 3'b000, 0, 3'b100, 8'h39, 0, 0));
    vecs.push_back(mk(0, 8'h00, 3'b000, 1, 3'b000, 8'h00, 1, 0));
    // Invalid address 3: no writes, no busy even with all FIFOs full (31..34).
    vecs.push_back(mk(1, 8'h07, 3'b111, 0, 3'b000, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'hAA, 3'b000, 0, 3'b000, 8'h00, 0, 0));
    vecs.push_back(mk(0, 8'hAD, 3'b000, 0, 3'b000, 8'h00, 0, 0));
    vecs.push_back(mk(0, 8'h00, 3'b000, 1, 3'b000, 8'h00, 1, 1));
    // Length mismatch: len 2, three payload bytes (35..40).
    vecs.push_back(mk(1, 8'h09, 3'b000, 0, 3'b010, 8'h09, 0, 0));
    vecs.push_back(mk(1, 8'h01, 3'b000, 0, 3'b010, 8'h01, 0, 0));
    vecs.push_back(mk(1, 8'h02, 3'b000, 0, 3'b010, 8'h02, 0, 0));
    vecs.push_back(mk(1, 8'h03, 3'b000, 0, 3'b010, 8'h03, 0, 0));
    vecs.push_back(mk(0, 8'h09, 3'b000, 0, 3'b010, 8'h09, 0, 0));
    vecs.push_back(mk(0, 8'h00, 3'b000, 1, 3'b000, 8'h00, 1, 1));
    // Zero-length packet to FIFO 2 (41..43).
    vecs.push_back(mk(1, 8'h02, 3'b000, 0, 3'b100, 8'h02, 0, 0));
    vecs.push_back(mk(0, 8'h02, 3'b000, 0, 3'b100, 8'h02, 0, 0));
    vecs.push_back(mk(0, 8'h00, 3'b000, 1, 3'b000, 8'h00, 1, 0));

    resetn    = 1'b0;
    pkt_valid = 1'b0;
    data_in   = 8'h00;
    fifo_full = 3'b000;
    #12;
    chk("rst_wr_en", -1, 32'(fifo_wr_en), 32'h0);
    chk("rst_din",   -1, 32'(fifo_din),   32'h0);
    chk("rst_err",   -1, 32'(err),        32'h0);
    chk("rst_done",  -1, 32'(pkt_done),   32'h0);
    chk("rst_busy",  -1, 32'(busy),       32'h0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    run(0, 43);

    // Reset mid-packet after the second payload byte of header 0x11.
    apply(mk(1, 8'h11, 3'b000, 0, 3'b010, 8'h11, 0, 0), 100);
    apply(mk(1, 8'h01, 3'b000, 0, 3'b010, 8'h01, 0, 0), 101);
    apply(mk(1, 8'h02, 3'b000, 0, 3'b010, 8'h02, 0, 0), 102);
    pkt_valid = 1'b0;
    data_in   = 8'h00;
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_wr_en", 103, 32'(fifo_wr_en), 32'h0);
    chk("mid_rst_din",   103, 32'(fifo_din),   32'h0);
    chk("mid_rst_err",   103, 32'(err),        32'h0);
    chk("mid_rst_done",  103, 32'(pkt_done),   32'h0);
    chk("mid_rst_busy",  103, 32'(busy),       32'h0);
    $display("vec 103 async reset asserted mid-packet");
    #2;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    // Only IDLE raises busy for header 0x11 while FIFO 1 is full (dest cleared to 0).
    apply(mk(1, 8'h11, 3'b010, 1, 3'b000, 8'h00, 0, 0), 104);
    run(2, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
